// File: rtl/axi3_pkg.sv
// Shared AXI3 response codes, burst encodings and FSM state types for the register bank.
package axi3_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

endpackage

// File: rtl/axi3_burst_addr.sv
// Per-channel burst address generator: tracks the current beat address and
// remaining beat count, and decodes register index / range for the beat.
// The *_nxt_c outputs expose the decode of the address the next cycle will
// hold, so the read side can prefetch a beat in the same cycle it is requested.
module axi3_burst_addr
    import axi3_pkg::*;
#(
    parameter int unsigned  N_REG = 8,
    parameter logic [31:0]  BASE  = 32'h4000_0000,
    localparam int unsigned IDX_W = $clog2(N_REG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [31:0]      addr,
    input  logic [3:0]       len,
    input  logic [1:0]       burst,
    input  logic             step,
    output logic [IDX_W-1:0] index,
    output logic             in_range,
    output logic             last,
    output logic             done,
    output logic [IDX_W-1:0] index_nxt_c,
    output logic             in_range_nxt_c,
    output logic             last_nxt_c
);

    localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * N_REG);

    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic [31:0] offset_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        incr_q;
    logic        incr_d;

    // Next address/count: load wins over step; only FIXED holds the address.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        incr_d = incr_q;
        if (load) begin
            addr_d = addr;
            cnt_d  = len;
            incr_d = (burst != BURST_FIXED);
        end else if (step) begin
            if (incr_q) begin
                addr_d = addr_q + 32'd4;
            end
            if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    // Decode of the upcoming beat address.
    always_comb begin
        offset_d       = addr_d - BASE;
        index_nxt_c    = IDX_W'(offset_d >> 2);
        in_range_nxt_c = ({1'b0, addr_d} >= {1'b0, BASE}) && ({1'b0, addr_d} < LIMIT);
        last_nxt_c     = (cnt_d == 4'd0);
    end

    // Burst state and registered decode of the current beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            cnt_q    <= '0;
            incr_q   <= 1'b0;
            index    <= '0;
            in_range <= 1'b0;
            last     <= 1'b0;
            done     <= 1'b1;
        end else begin
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            incr_q   <= incr_d;
            index    <= index_nxt_c;
            in_range <= in_range_nxt_c;
            last     <= last_nxt_c;
            if (load) begin
                done <= 1'b0;
            end else if (step && last) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi3_regbank.sv
// AXI3 slave register bank: N_REG byte-strobed 32-bit registers with
// independent write and read channels, FIXED/INCR bursts and SLVERR on
// out-of-range beats. One register's low bits drive the LEDs.
module axi3_regbank
    import axi3_pkg::*;
#(
    parameter int unsigned N_REG   = 8,
    parameter logic [31:0] BASE    = 32'h4000_0000,
    parameter int unsigned ID_W    = 12,
    parameter int unsigned LED_W   = 8,
    parameter int unsigned LED_REG = 0
) (
    input  logic                 i_clk0,
    input  logic                 i_rst,
    input  logic [ID_W-1:0]      i_M_AXI_GP0_AWID,
    input  logic [31:0]          i_M_AXI_GP0_AWADDR,
    input  logic [3:0]           i_M_AXI_GP0_AWLEN,
    input  logic [2:0]           i_M_AXI_GP0_AWSIZE,
    input  logic [1:0]           i_M_AXI_GP0_AWBURST,
    input  logic [1:0]           i_M_AXI_GP0_AWLOCK,
    input  logic [3:0]           i_M_AXI_GP0_AWCACHE,
    input  logic [2:0]           i_M_AXI_GP0_AWPROT,
    input  logic [3:0]           i_M_AXI_GP0_AWQOS,
    input  logic                 i_M_AXI_GP0_AWVALID,
    output logic                 o_M_AXI_GP0_AWREADY,
    input  logic [ID_W-1:0]      i_M_AXI_GP0_WID,
    input  logic [31:0]          i_M_AXI_GP0_WDATA,
    input  logic [3:0]           i_M_AXI_GP0_WSTRB,
    input  logic                 i_M_AXI_GP0_WLAST,
    input  logic                 i_M_AXI_GP0_WVALID,
    output logic                 o_M_AXI_GP0_WREADY,
    output logic [ID_W-1:0]      o_M_AXI_GP0_BID,
    output logic [1:0]           o_M_AXI_GP0_BRESP,
    output logic                 o_M_AXI_GP0_BVALID,
    input  logic                 i_M_AXI_GP0_BREADY,
    input  logic [ID_W-1:0]      i_M_AXI_GP0_ARID,
    input  logic [31:0]          i_M_AXI_GP0_ARADDR,
    input  logic [3:0]           i_M_AXI_GP0_ARLEN,
    input  logic [2:0]           i_M_AXI_GP0_ARSIZE,
    input  logic [1:0]           i_M_AXI_GP0_ARBURST,
    input  logic [1:0]           i_M_AXI_GP0_ARLOCK,
    input  logic [3:0]           i_M_AXI_GP0_ARCACHE,
    input  logic [2:0]           i_M_AXI_GP0_ARPROT,
    input  logic [3:0]           i_M_AXI_GP0_ARQOS,
    input  logic                 i_M_AXI_GP0_ARVALID,
    output logic                 o_M_AXI_GP0_ARREADY,
    output logic [ID_W-1:0]      o_M_AXI_GP0_RID,
    output logic [31:0]          o_M_AXI_GP0_RDATA,
    output logic [1:0]           o_M_AXI_GP0_RRESP,
    output logic                 o_M_AXI_GP0_RLAST,
    output logic                 o_M_AXI_GP0_RVALID,
    input  logic                 i_M_AXI_GP0_RREADY,
    output logic [LED_W-1:0]     o_led,
    output logic [32*N_REG-1:0]  o_regs
);

    localparam int unsigned      IDX_W   = $clog2(N_REG);
    localparam logic [IDX_W-1:0] LED_IDX = IDX_W'(LED_REG);

    logic [31:0] regs_q [N_REG];

    wstate_t w_state_q;
    wstate_t w_state_d;
    rstate_t r_state_q;
    rstate_t r_state_d;

    logic aw_hs_c;
    logic w_hs_c;
    logic ar_hs_c;
    logic r_hs_c;
    logic wr_err_q;

    logic [31:0] wr_mask_c;
    logic [31:0] wr_word_c;

    logic [IDX_W-1:0] wa_index;
    logic             wa_in_range;
    logic             wa_last;
    logic             wa_done;
    logic [IDX_W-1:0] wa_index_nxt_c;
    logic             wa_in_range_nxt_c;
    logic             wa_last_nxt_c;

    logic [IDX_W-1:0] ra_index;
    logic             ra_in_range;
    logic             ra_last;
    logic             ra_done;
    logic [IDX_W-1:0] ra_index_nxt_c;
    logic             ra_in_range_nxt_c;
    logic             ra_last_nxt_c;

    // Write-channel beat address tracker.
    axi3_burst_addr #(
        .N_REG (N_REG),
        .BASE  (BASE)
    ) u_wr_addr (
        .clk            (i_clk0),
        .rst            (i_rst),
        .load           (aw_hs_c),
        .addr           (i_M_AXI_GP0_AWADDR),
        .len            (i_M_AXI_GP0_AWLEN),
        .burst          (i_M_AXI_GP0_AWBURST),
        .step           (w_hs_c),
        .index          (wa_index),
        .in_range       (wa_in_range),
        .last           (wa_last),
        .done           (wa_done),
        .index_nxt_c    (wa_index_nxt_c),
        .in_range_nxt_c (wa_in_range_nxt_c),
        .last_nxt_c     (wa_last_nxt_c)
    );

    // Read-channel beat address tracker.
    axi3_burst_addr #(
        .N_REG (N_REG),
        .BASE  (BASE)
    ) u_rd_addr (
        .clk            (i_clk0),
        .rst            (i_rst),
        .load           (ar_hs_c),
        .addr           (i_M_AXI_GP0_ARADDR),
        .len            (i_M_AXI_GP0_ARLEN),
        .burst          (i_M_AXI_GP0_ARBURST),
        .step           (r_hs_c),
        .index          (ra_index),
        .in_range       (ra_in_range),
        .last           (ra_last),
        .done           (ra_done),
        .index_nxt_c    (ra_index_nxt_c),
        .in_range_nxt_c (ra_in_range_nxt_c),
        .last_nxt_c     (ra_last_nxt_c)
    );

    // Write FSM next state and handshake strobes.
    always_comb begin
        w_state_d = w_state_q;
        aw_hs_c   = 1'b0;
        w_hs_c    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (i_M_AXI_GP0_AWVALID) begin
                    aw_hs_c   = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (i_M_AXI_GP0_WVALID) begin
                    w_hs_c = 1'b1;
                    if (wa_last) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (i_M_AXI_GP0_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM state, channel outputs and sticky burst error.
    always_ff @(posedge i_clk0 or posedge i_rst) begin
        if (i_rst) begin
            w_state_q           <= W_IDLE;
            o_M_AXI_GP0_AWREADY <= 1'b1;
            o_M_AXI_GP0_WREADY  <= 1'b0;
            o_M_AXI_GP0_BVALID  <= 1'b0;
            o_M_AXI_GP0_BID     <= '0;
            o_M_AXI_GP0_BRESP   <= RESP_OKAY;
            wr_err_q            <= 1'b0;
        end else begin
            w_state_q           <= w_state_d;
            o_M_AXI_GP0_AWREADY <= (w_state_d == W_IDLE);
            o_M_AXI_GP0_WREADY  <= (w_state_d == W_DATA);
            o_M_AXI_GP0_BVALID  <= (w_state_d == W_RESP);
            if (aw_hs_c) begin
                o_M_AXI_GP0_BID   <= i_M_AXI_GP0_AWID;
                o_M_AXI_GP0_BRESP <= RESP_OKAY;
                wr_err_q          <= 1'b0;
            end
            if (w_hs_c && !wa_in_range) begin
                wr_err_q <= 1'b1;
            end
            if (w_hs_c && wa_last) begin
                o_M_AXI_GP0_BRESP <= (wr_err_q || !wa_in_range) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Byte-strobe merge of the incoming beat into the addressed register.
    always_comb begin
        wr_mask_c = {{8{i_M_AXI_GP0_WSTRB[3]}}, {8{i_M_AXI_GP0_WSTRB[2]}},
                     {8{i_M_AXI_GP0_WSTRB[1]}}, {8{i_M_AXI_GP0_WSTRB[0]}}};
        wr_word_c = (regs_q[wa_index] & ~wr_mask_c) | (i_M_AXI_GP0_WDATA & wr_mask_c);
    end

    // Register file: only in-range write beats update it.
    always_ff @(posedge i_clk0 or posedge i_rst) begin
        if (i_rst) begin
            regs_q <= '{default: '0};
        end else if (w_hs_c && wa_in_range) begin
            regs_q[wa_index] <= wr_word_c;
        end
    end

    // Read FSM next state and handshake strobes.
    always_comb begin
        r_state_d = r_state_q;
        ar_hs_c   = 1'b0;
        r_hs_c    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (i_M_AXI_GP0_ARVALID) begin
                    ar_hs_c   = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (i_M_AXI_GP0_RREADY) begin
                    r_hs_c = 1'b1;
                    if (ra_last) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM state and beat prefetch into the R channel registers.
    always_ff @(posedge i_clk0 or posedge i_rst) begin
        if (i_rst) begin
            r_state_q           <= R_IDLE;
            o_M_AXI_GP0_ARREADY <= 1'b1;
            o_M_AXI_GP0_RVALID  <= 1'b0;
            o_M_AXI_GP0_RLAST   <= 1'b0;
            o_M_AXI_GP0_RID     <= '0;
            o_M_AXI_GP0_RDATA   <= '0;
            o_M_AXI_GP0_RRESP   <= RESP_OKAY;
        end else begin
            r_state_q           <= r_state_d;
            o_M_AXI_GP0_ARREADY <= (r_state_d == R_IDLE);
            o_M_AXI_GP0_RVALID  <= (r_state_d == R_DATA);
            if (ar_hs_c) begin
                o_M_AXI_GP0_RID <= i_M_AXI_GP0_ARID;
            end
            if (ar_hs_c || (r_hs_c && !ra_last)) begin
                o_M_AXI_GP0_RDATA <= ra_in_range_nxt_c ? regs_q[ra_index_nxt_c] : 32'd0;
                o_M_AXI_GP0_RRESP <= ra_in_range_nxt_c ? RESP_OKAY : RESP_SLVERR;
                o_M_AXI_GP0_RLAST <= ra_last_nxt_c;
            end else if (r_hs_c) begin
                o_M_AXI_GP0_RLAST <= 1'b0;
            end
        end
    end

    // Register contents exported flat and to the LEDs.
    for (genvar g = 0; g < N_REG; g++) begin : g_regs_out
        assign o_regs[32*g +: 32] = regs_q[g];
    end

    assign o_led = regs_q[LED_IDX][LED_W-1:0];

    // Sideband fields this slave does not act on.
    logic unused_inputs;
    assign unused_inputs = ^{i_M_AXI_GP0_AWSIZE, i_M_AXI_GP0_AWLOCK, i_M_AXI_GP0_AWCACHE,
                             i_M_AXI_GP0_AWPROT, i_M_AXI_GP0_AWQOS, i_M_AXI_GP0_WID,
                             i_M_AXI_GP0_WLAST, i_M_AXI_GP0_ARSIZE, i_M_AXI_GP0_ARLOCK,
                             i_M_AXI_GP0_ARCACHE, i_M_AXI_GP0_ARPROT, i_M_AXI_GP0_ARQOS,
                             wa_done, wa_index_nxt_c, wa_in_range_nxt_c, wa_last_nxt_c,
                             ra_done, ra_index, ra_in_range};

endmodule

// File: tb/tb_axi3_regbank.sv
// Directed bench for axi3_regbank: one task per scenario with inline checks.
module tb_axi3_regbank;
    import axi3_pkg::*;

    localparam int unsigned N_REG = 8;
    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int unsigned ID_W  = 12;
    localparam int unsigned LED_W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [ID_W-1:0] awid, wid, bid, arid, rid;
    logic [31:0]     awaddr, wdata, araddr, rdata;
    logic [3:0]      awlen, arlen, wstrb;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [LED_W-1:0]     led;
    logic [32*N_REG-1:0]  regs;

    axi3_regbank #(
        .N_REG (N_REG), .BASE (BASE), .ID_W (ID_W), .LED_W (LED_W), .LED_REG (0)
    ) dut (
        .i_clk0 (clk), .i_rst (rst),
        .i_M_AXI_GP0_AWID (awid), .i_M_AXI_GP0_AWADDR (awaddr), .i_M_AXI_GP0_AWLEN (awlen),
        .i_M_AXI_GP0_AWSIZE (awsize), .i_M_AXI_GP0_AWBURST (awburst),
        .i_M_AXI_GP0_AWLOCK (2'b00), .i_M_AXI_GP0_AWCACHE (4'h0), .i_M_AXI_GP0_AWPROT (3'b000),
        .i_M_AXI_GP0_AWQOS (4'h0), .i_M_AXI_GP0_AWVALID (awvalid), .o_M_AXI_GP0_AWREADY (awready),
        .i_M_AXI_GP0_WID (wid), .i_M_AXI_GP0_WDATA (wdata), .i_M_AXI_GP0_WSTRB (wstrb),
        .i_M_AXI_GP0_WLAST (wlast), .i_M_AXI_GP0_WVALID (wvalid), .o_M_AXI_GP0_WREADY (wready),
        .o_M_AXI_GP0_BID (bid), .o_M_AXI_GP0_BRESP (bresp), .o_M_AXI_GP0_BVALID (bvalid),
        .i_M_AXI_GP0_BREADY (bready),
        .i_M_AXI_GP0_ARID (arid), .i_M_AXI_GP0_ARADDR (araddr), .i_M_AXI_GP0_ARLEN (arlen),
        .i_M_AXI_GP0_ARSIZE (arsize), .i_M_AXI_GP0_ARBURST (arburst),
        .i_M_AXI_GP0_ARLOCK (2'b00), .i_M_AXI_GP0_ARCACHE (4'h0), .i_M_AXI_GP0_ARPROT (3'b000),
        .i_M_AXI_GP0_ARQOS (4'h0), .i_M_AXI_GP0_ARVALID (arvalid), .o_M_AXI_GP0_ARREADY (arready),
        .o_M_AXI_GP0_RID (rid), .o_M_AXI_GP0_RDATA (rdata), .o_M_AXI_GP0_RRESP (rresp),
        .o_M_AXI_GP0_RLAST (rlast), .o_M_AXI_GP0_RVALID (rvalid), .i_M_AXI_GP0_RREADY (rready),
        .o_led (led), .o_regs (regs)
    );

    int total  = 0;
    int passed = 0;

    logic [31:0]     exp_regs [N_REG];
    logic [31:0]     rd_data  [16];
    logic [1:0]      rd_resp  [16];
    logic            rd_last  [16];
    logic [ID_W-1:0] rd_id;
    logic [1:0]      b_resp;
    logic [ID_W-1:0] b_id;

    function automatic logic [32*N_REG-1:0] flat_exp();
        logic [32*N_REG-1:0] f;
        for (int i = 0; i < int'(N_REG); i++) f[32*i +: 32] = exp_regs[i];
        return f;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < int'(N_REG); i++) exp_regs[i] = 32'd0;
    endtask

    task automatic send_aw(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
        for (int n = 0; n < 50 && !awready; n++) begin @(posedge clk); #1; end
        if (!awready) begin
            total++;
            $display("FAIL aw_timeout awready=%b required 1", awready);
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        wdata = data; wstrb = strb; wvalid = 1'b1;
        for (int n = 0; n < 50 && !wready; n++) begin @(posedge clk); #1; end
        if (!wready) begin
            total++;
            $display("FAIL w_timeout wready=%b required 1", wready);
        end
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic wait_b();
        bready = 1'b1;
        for (int n = 0; n < 50 && !bvalid; n++) begin @(posedge clk); #1; end
        if (!bvalid) begin
            total++;
            $display("FAIL b_timeout bvalid=%b required 1", bvalid);
        end
        b_resp = bresp; b_id = bid;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic write_single(input logic [ID_W-1:0] id, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb);
        send_aw(id, addr, 4'd0, BURST_INCR);
        send_w(data, strb);
        wait_b();
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst, input bit rnd);
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
        for (int n = 0; n < 50 && !arready; n++) begin @(posedge clk); #1; end
        if (!arready) begin
            total++;
            $display("FAIL ar_timeout arready=%b required 1", arready);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            int n = 0;
            rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!(rvalid && rready) && n < 200) begin
                @(posedge clk); #1;
                n++;
                rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!(rvalid && rready)) begin
                total++;
                $display("FAIL r_timeout beat=%0d rvalid=%b required 1", k, rvalid);
            end
            rd_data[k] = rdata; rd_resp[k] = rresp; rd_last[k] = rlast;
            if (k == 0) rd_id = rid;
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (awready !== 1'b1) $display("FAIL reset_awready got %b want 1", awready); else passed++;
        total++; if (arready !== 1'b1) $display("FAIL reset_arready got %b want 1", arready); else passed++;
        total++; if ({wready, bvalid, rvalid, rlast} !== 4'b0000)
            $display("FAIL reset_valids got %b want 0000", {wready, bvalid, rvalid, rlast}); else passed++;
        total++; if ({bid, rid, rdata, bresp, rresp} !== '0)
            $display("FAIL reset_ids_data got %h %h %h %b %b want zeros", bid, rid, rdata, bresp, rresp); else passed++;
        total++; if (led !== 8'h00) $display("FAIL reset_led got %h want 00", led); else passed++;
        total++; if (regs !== '0) $display("FAIL reset_regs got %h want 0", regs); else passed++;
    endtask

    task automatic test_single_write();
        send_aw(12'h123, BASE, 4'd0, BURST_INCR);
        total++; if (wready !== 1'b1) $display("FAIL sw_wready_after_aw got %b want 1", wready); else passed++;
        send_w(32'h0000_00A5, 4'hF);
        exp_regs[0] = 32'h0000_00A5;
        total++; if (led !== 8'hA5) $display("FAIL sw_led got %h want a5", led); else passed++;
        total++; if (bvalid !== 1'b1) $display("FAIL sw_bvalid_after_last got %b want 1", bvalid); else passed++;
        wait_b();
        total++; if (b_resp !== RESP_OKAY) $display("FAIL sw_bresp got %b want 00", b_resp); else passed++;
        total++; if (b_id !== 12'h123) $display("FAIL sw_bid got %h want 123", b_id); else passed++;
        total++; if (awready !== 1'b1) $display("FAIL sw_awready_after_b got %b want 1", awready); else passed++;
    endtask

    task automatic test_strobes();
        write_single(12'h001, BASE + 32'd4, 32'h1122_3344, 4'hF);
        write_single(12'h002, BASE + 32'd4, 32'hFFFF_FFFF, 4'b0101);
        exp_regs[1] = 32'h11FF_33FF;
        do_read(12'h0AB, BASE + 32'd4, 4'd0, BURST_INCR, 1'b0);
        total++; if (rd_data[0] !== 32'h11FF_33FF) $display("FAIL strb_rdata got %h want 11ff33ff", rd_data[0]); else passed++;
        total++; if ({rd_resp[0], rd_last[0]} !== {RESP_OKAY, 1'b1})
            $display("FAIL strb_rresp_rlast got %b %b want 00 1", rd_resp[0], rd_last[0]); else passed++;
        total++; if (rd_id !== 12'h0AB) $display("FAIL strb_rid got %h want 0ab", rd_id); else passed++;
    endtask

    task automatic test_incr_burst();
        send_aw(12'h045, BASE + 32'd8, 4'd3, BURST_INCR);
        for (int k = 0; k < 4; k++) send_w(32'(k + 1), 4'hF);
        wait_b();
        for (int k = 0; k < 4; k++) exp_regs[2 + k] = 32'(k + 1);
        total++; if (b_resp !== RESP_OKAY || b_id !== 12'h045)
            $display("FAIL incr_b got %b %h want 00 045", b_resp, b_id); else passed++;
        total++; if (regs !== flat_exp()) $display("FAIL incr_regs got %h want %h", regs, flat_exp()); else passed++;
        do_read(12'h046, BASE + 32'd8, 4'd3, BURST_INCR, 1'b1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (rd_data[k] !== 32'(k + 1) || rd_resp[k] !== RESP_OKAY || rd_last[k] !== (k == 3))
                $display("FAIL incr_rbeat%0d got %h %b %b want %h 00 %b",
                         k, rd_data[k], rd_resp[k], rd_last[k], 32'(k + 1), (k == 3));
            else passed++;
        end
        // Back-to-back beats with RREADY held high.
        do_read(12'h047, BASE + 32'd8, 4'd1, BURST_INCR, 1'b0);
        total++; if (rd_data[0] !== 32'd1 || rd_data[1] !== 32'd2)
            $display("FAIL b2b_rdata got %h %h want 1 2", rd_data[0], rd_data[1]); else passed++;
    endtask

    task automatic test_fixed_burst();
        send_aw(12'h0F0, BASE + 32'h1C, 4'd1, BURST_FIXED);
        send_w(32'd7, 4'hF);
        send_w(32'd8, 4'hF);
        wait_b();
        exp_regs[7] = 32'd8;
        total++; if (regs !== flat_exp()) $display("FAIL fixed_regs got %h want %h", regs, flat_exp()); else passed++;
    endtask

    task automatic test_out_of_range();
        write_single(12'h0EE, BASE + 32'd32, 32'hDEAD_BEEF, 4'hF);
        total++; if (b_resp !== RESP_SLVERR || b_id !== 12'h0EE)
            $display("FAIL oor_b got %b %h want 10 0ee", b_resp, b_id); else passed++;
        total++; if (regs !== flat_exp()) $display("FAIL oor_regs got %h want %h", regs, flat_exp()); else passed++;
        do_read(12'h0EF, BASE + 32'd32, 4'd0, BURST_INCR, 1'b0);
        total++; if (rd_data[0] !== 32'd0 || rd_resp[0] !== RESP_SLVERR)
            $display("FAIL oor_read got %h %b want 0 10", rd_data[0], rd_resp[0]); else passed++;
        do_read(12'h0E1, BASE - 32'd4, 4'd0, BURST_INCR, 1'b0);
        total++; if (rd_resp[0] !== RESP_SLVERR) $display("FAIL below_base_rresp got %b want 10", rd_resp[0]); else passed++;
        // Burst crossing the top: only the second beat errors.
        do_read(12'h0E0, BASE + 32'h1C, 4'd1, BURST_INCR, 1'b0);
        total++; if (rd_data[0] !== 32'd8 || rd_resp[0] !== RESP_OKAY || rd_last[0] !== 1'b0)
            $display("FAIL cross_beat0 got %h %b %b want 8 00 0", rd_data[0], rd_resp[0], rd_last[0]); else passed++;
        total++; if (rd_data[1] !== 32'd0 || rd_resp[1] !== RESP_SLVERR || rd_last[1] !== 1'b1)
            $display("FAIL cross_beat1 got %h %b %b want 0 10 1", rd_data[1], rd_resp[1], rd_last[1]); else passed++;
        // Write burst crossing the top: first beat lands, BRESP sticky SLVERR.
        send_aw(12'h0E2, BASE + 32'h1C, 4'd1, BURST_INCR);
        send_w(32'd9, 4'hF);
        send_w(32'd10, 4'hF);
        wait_b();
        exp_regs[7] = 32'd9;
        total++; if (b_resp !== RESP_SLVERR) $display("FAIL cross_wr_bresp got %b want 10", b_resp); else passed++;
        total++; if (regs !== flat_exp()) $display("FAIL cross_wr_regs got %h want %h", regs, flat_exp()); else passed++;
    endtask

    task automatic test_reset_mid_burst();
        send_aw(12'h777, BASE + 32'h10, 4'd3, BURST_INCR);
        send_w(32'hAAAA_0001, 4'hF);
        exp_regs[4] = 32'hAAAA_0001;
        total++; if (regs !== flat_exp()) $display("FAIL mid_beat1 got %h want %h", regs, flat_exp()); else passed++;
        wdata = 32'hAAAA_0002; wvalid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        total++; if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000)
            $display("FAIL mid_rst_ctrl got %b want 11000", {awready, arready, wready, bvalid, rvalid}); else passed++;
        total++; if (regs !== '0 || led !== 8'h00 || bid !== '0)
            $display("FAIL mid_rst_state got %h %h %h want zeros", regs, led, bid); else passed++;
        wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        write_single(12'h321, BASE, 32'h0000_005A, 4'hF);
        exp_regs[0] = 32'h0000_005A;
        total++; if (b_resp !== RESP_OKAY || b_id !== 12'h321 || led !== 8'h5A)
            $display("FAIL post_rst_write got %b %h %h want 00 321 5a", b_resp, b_id, led); else passed++;
        total++; if (regs !== flat_exp()) $display("FAIL post_rst_regs got %h want %h", regs, flat_exp()); else passed++;
    endtask

    task automatic test_concurrent();
        write_single(12'h010, BASE + 32'hC, 32'hCAFE_F00D, 4'hF);
        exp_regs[3] = 32'hCAFE_F00D;
        send_aw(12'h011, BASE + 32'hC, 4'd0, BURST_INCR);
        wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
        arid = 12'h012; araddr = BASE + 32'hC; arlen = 4'd0; arburst = BURST_INCR; arvalid = 1'b1;
        total++; if (wready !== 1'b1 || arready !== 1'b1)
            $display("FAIL conc_ready got %b %b want 1 1", wready, arready); else passed++;
        @(posedge clk); #1;
        wvalid = 1'b0; arvalid = 1'b0;
        exp_regs[3] = 32'h1234_5678;
        total++; if (rvalid !== 1'b1 || rdata !== 32'hCAFE_F00D)
            $display("FAIL conc_old_read got %b %h want 1 cafef00d", rvalid, rdata); else passed++;
        total++; if (regs !== flat_exp()) $display("FAIL conc_regs got %h want %h", regs, flat_exp()); else passed++;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        wait_b();
        do_read(12'h013, BASE + 32'hC, 4'd0, BURST_INCR, 1'b0);
        total++; if (rd_data[0] !== 32'h1234_5678) $display("FAIL conc_new_read got %h want 12345678", rd_data[0]); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_strobes();
        test_incr_burst();
        test_fixed_burst();
        test_out_of_range();
        test_reset_mid_burst();
        test_concurrent();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
